// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions.
//   INSTR_W / PC_STEP : instruction word width and sequential PC increment.
//   OP_J / OP_JAL     : opcodes for later predecode of direct jumps.
//   fetch_entry_t     : one queued fetch result {pc, instr}. The pc field is
//                       PC_W wide; narrower address widths sit in the low bits.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam int PC_W    = 32;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch_entry_t, DEPTH entries (power of two).
//   clock, reset : clock and asynchronous active-low reset (control only).
//   flush        : empties the queue; overrides push and pop.
//   push/entry   : write one entry at the tail.
//   pop          : drop the head entry.
//   head         : current head entry (valid when count != 0).
//   count        : number of stored entries, 0..DEPTH.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               entry,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked entirely by count.
  // A push into a full queue together with a pop overwrites the slot being
  // popped, which is safe because the head is read from registered state.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled instruction-fetch front end.
//   clock, reset          : clock, asynchronous active-low reset.
//   imem_req_*            : word fetch requests (valid/ready), word-aligned.
//   imem_rsp_*            : in-order responses, always accepted.
//   redirect_valid/_pc    : restart fetch at redirect_pc (low bits cleared),
//                           flushing the queue and discarding stale responses.
//   out_valid/ready       : head-of-queue handshake to decode.
//   out_instr/pc/pc_plus4 : head instruction, its PC, and PC + 4.
module ifetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus4
);

  localparam int IW = $clog2(MAX_OUT+1);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;
  localparam logic [IW-1:0]     MAX_OUT_C  = IW'(MAX_OUT);
  localparam logic [CW:0]       DEPTH_C    = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [IW-1:0]     inflight;
  logic [IW-1:0]     inflight_nxt;
  logic [IW-1:0]     drop_cnt;
  logic [IW-1:0]     drop_nxt;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic [ADDR_W-1:0] redirect_pc_a;
  logic              req_fire;
  logic              rsp_dec;
  logic              push;
  logic              pop;
  logic              q_nonempty;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

  assign redirect_pc_a = redirect_pc & ALIGN_MASK;

  // Credit rule: entries held plus responses owed never exceed DEPTH, so a
  // response always finds a free slot. Gated by reset so nothing is offered
  // while the block is held in reset.
  assign occupancy      = {1'b0, count} + (CW+1)'(inflight);
  assign imem_req_valid = reset && !redirect_valid &&
                          (inflight < MAX_OUT_C) && (occupancy < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response arriving with nothing outstanding (one requested before a
  // reset) must not wrap the counter.
  assign rsp_dec = imem_rsp_valid && (inflight != '0);
  assign push    = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign q_nonempty = (count != '0);
  assign out_valid  = q_nonempty && !redirect_valid;
  assign pop        = out_valid && out_ready;

  assign push_entry = '{pc: PC_W'(rsp_pc), instr: imem_rsp_data};

  always_comb begin
    inflight_nxt = inflight + IW'(req_fire) - IW'(rsp_dec);
    drop_nxt     = drop_cnt;
    if (redirect_valid)
      // Everything still owed is stale; one arriving now is dropped in place.
      drop_nxt = inflight - IW'(rsp_dec);
    else if (imem_rsp_valid && (drop_cnt != '0))
      drop_nxt = drop_cnt - IW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC_A;
      rsp_pc   <= RESET_PC_A;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_nxt;
      drop_cnt <= drop_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc_a;
        rsp_pc   <= redirect_pc_a;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (push)     rsp_pc   <= rsp_pc + STEP;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock (clock),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .entry (push_entry),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  // With the queue empty the PC outputs show where the next entry will land.
  assign out_instr    = q_nonempty ? head.instr : '0;
  assign out_pc       = q_nonempty ? head.pc[ADDR_W-1:0] : rsp_pc;
  assign out_pc_plus4 = out_pc + STEP;

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  ifetch_queue #(
    .ADDR_W   (32),
    .RESET_PC (32'h0),
    .DEPTH    (4),
    .MAX_OUT  (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t pend[$];

  typedef struct {
    bit          rst;
    int          lat;
    bit          redir;
    logic [31:0] rpc;
    bit          ordy;
    bit          mrdy;
    bit          ev;
    logic [31:0] ea;
    bit          ov;
    logic [31:0] op;
  } vec_t;
  vec_t vq[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input bit rst, input int l, input bit redir, input logic [31:0] rpc,
                     input bit ordy, input bit mrdy, input bit ev, input logic [31:0] ea,
                     input bit ov, input logic [31:0] op);
    vec_t v;
    v.rst = rst; v.lat = l; v.redir = redir; v.rpc = rpc; v.ordy = ordy; v.mrdy = mrdy;
    v.ev = ev; v.ea = ea; v.ov = ov; v.op = op;
    vq.push_back(v);
  endtask

  // Memory model: present the oldest response once its latency has elapsed.
  task automatic drive_mem();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic edge_update();
    bit          fire;
    bit          took;
    logic [31:0] a;
    fire = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    took = imem_rsp_valid;
    @(posedge clock);
    if (took) void'(pend.pop_front());
    if (fire) pend.push_back('{addr: a, due: cyc + lat});
    cyc++;
  endtask

  task automatic do_reset(input int l);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend.delete();
    lat = l;
    repeat (2) @(negedge clock);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    // Stream with a one-cycle stall on the request channel.
    add(1,1,0,0,1,1, 1,32'h00, 0,0);
    add(0,1,0,0,1,1, 1,32'h04, 0,0);
    add(0,1,0,0,1,1, 1,32'h08, 1,32'h00);
    add(0,1,0,0,1,0, 1,32'h0C, 1,32'h04);
    add(0,1,0,0,1,1, 1,32'h0C, 1,32'h08);
    add(0,1,0,0,1,1, 1,32'h10, 0,0);
    add(0,1,0,0,1,1, 1,32'h14, 1,32'h0C);
    add(0,1,0,0,1,1, 1,32'h18, 1,32'h10);
    // Decode stalled: fill to DEPTH, then drain in order.
    add(1,1,0,0,0,1, 1,32'h00, 0,0);
    add(0,1,0,0,0,1, 1,32'h04, 0,0);
    add(0,1,0,0,0,1, 1,32'h08, 1,32'h00);
    add(0,1,0,0,0,1, 1,32'h0C, 1,32'h00);
    add(0,1,0,0,0,1, 0,0,      1,32'h00);
    add(0,1,0,0,0,1, 0,0,      1,32'h00);
    add(0,1,0,0,1,1, 0,0,      1,32'h00);
    add(0,1,0,0,1,1, 1,32'h10, 1,32'h04);
    add(0,1,0,0,1,1, 1,32'h14, 1,32'h08);
    add(0,1,0,0,1,1, 1,32'h18, 1,32'h0C);
    add(0,1,0,0,1,1, 1,32'h1C, 1,32'h10);
    // Latency 3, redirect to 0x40 with two requests outstanding.
    add(1,3,0,0,1,1,      1,32'h00, 0,0);
    add(0,3,0,0,1,1,      1,32'h04, 0,0);
    add(0,3,1,32'h40,1,1, 0,0,      0,0);
    add(0,3,0,0,1,1,      0,0,      0,0);
    add(0,3,0,0,1,1,      1,32'h40, 0,0);
    add(0,3,0,0,1,1,      1,32'h44, 0,0);
    add(0,3,0,0,1,1,      0,0,      0,0);
    add(0,3,0,0,1,1,      0,0,      0,0);
    add(0,3,0,0,1,1,      1,32'h48, 1,32'h40);
    add(0,3,0,0,1,1,      1,32'h4C, 1,32'h44);
    add(0,3,0,0,1,1,      0,0,      0,0);
    add(0,3,0,0,1,1,      0,0,      0,0);
    add(0,3,0,0,1,1,      1,32'h50, 1,32'h48);
    // Unaligned redirect target, minimum redirect latency.
    add(1,1,1,32'h103,1,1, 0,0,       0,0);
    add(0,1,0,0,1,1,       1,32'h100, 0,0);
    add(0,1,0,0,1,1,       1,32'h104, 0,0);
    add(0,1,0,0,1,1,       1,32'h108, 1,32'h100);
    add(0,1,0,0,1,1,       1,32'h10C, 1,32'h104);
    // Redirect colliding with a response and a ready decode stage.
    add(1,1,0,0,1,1,       1,32'h00,  0,0);
    add(0,1,0,0,1,1,       1,32'h04,  0,0);
    add(0,1,1,32'h200,1,1, 0,0,       0,0);
    add(0,1,0,0,1,1,       1,32'h200, 0,0);
    add(0,1,0,0,1,1,       1,32'h204, 0,0);
    add(0,1,0,0,1,1,       1,32'h208, 1,32'h200);

    @(negedge clock);
    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) do_reset(vq[i].lat);
      redirect_valid = vq[i].redir;
      redirect_pc    = vq[i].rpc;
      out_ready      = vq[i].ordy;
      imem_req_ready = vq[i].mrdy;
      drive_mem();
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vq[i].ev});
      if (vq[i].ev) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vq[i].ea);
      chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vq[i].ov});
      if (vq[i].ov) begin
        chk($sformatf("v%0d_out_pc", i), out_pc, vq[i].op);
        chk($sformatf("v%0d_out_pc_plus4", i), out_pc_plus4, vq[i].op + 32'd4);
        chk($sformatf("v%0d_out_instr", i), out_instr, instr_of(vq[i].op));
      end
      edge_update();
      @(negedge clock);
    end

    // Reset with one entry queued and one response still owed by memory; the
    // memory is not reset and delivers that response just after release.
    do_reset(3);
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b1;
    repeat (3) begin
      drive_mem();
      #1;
      edge_update();
      @(negedge clock);
    end
    drive_mem();
    #1;
    edge_update();
    #1;
    chk("mid_pre_out_valid", {31'b0, out_valid}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_out_instr", out_instr, 32'h0);
    chk("mid_rst_out_pc", out_pc, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    drive_mem();
    #1;
    chk("late_rsp_present", {31'b0, imem_rsp_valid}, 32'h1);
    chk("restart_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("restart_req_addr", imem_req_addr, 32'h0);
    edge_update();
    @(negedge clock);
    drive_mem();
    #1;
    chk("late_out_valid", {31'b0, out_valid}, 32'h1);
    chk("late_out_pc", out_pc, 32'h0);
    chk("late_out_pc_plus4", out_pc_plus4, 32'h4);
    chk("late_out_instr", out_instr, instr_of(32'h4));
    chk("late_req_addr", imem_req_addr, 32'h4);
    edge_update();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised, decoupled instruction-fetch front end for the MIPS CPU.
- Issues sequential word fetches to an instruction memory over a valid/ready request channel, with in-order responses. Buffers fetched instructions with their PC in a DEPTH-entry queue.
- Presents instructions to decode over a valid/ready handshake.
- Execute-stage redirects (branch taken, j, jal, jr) flush the queue and discard stale in-flight responses. PC+4 is supplied for branch-base and jal link use.

Parameters:
- ADDR_W, 32: PC and memory byte-address width.
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- DEPTH, 4: instruction queue entries (power of two, ≥2).
- MAX_OUT, 2: maximum outstanding memory requests (≥1, ≤DEPTH).

Ports:
- clock  in  1  single clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  ADDR_W  word-aligned byte address; bits [1:0] are always 0.
- imem_rsp_valid  in  1  response valid; always accepted, in request order.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  redirect the fetch stream.
- redirect_pc  in  ADDR_W  new fetch target; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode consumes the head.
- out_instr  out  32  head instruction.
- out_pc  out  ADDR_W  head PC.
- out_pc_plus4  out  ADDR_W  out_pc + 4 (branch base and link address).

Behaviour:
- Reset (reset low, asynchronous):
  - fetch_pc = rsp_pc = RESET_PC.
  - Queue is empty; inflight = 0; drop_cnt = 0.
  - imem_req_valid = 0, out_valid = 0, out_instr = 0, out_pc = RESET_PC.
- Request issue:
  - imem_req_valid = !redirect_valid && inflight < MAX_OUT && (count + inflight) < DEPTH.
  - This credit rule makes queue overflow impossible.
  - On handshake: inflight++ and fetch_pc += 4 (wraps modulo 2^ADDR_W).
  - imem_req_addr = fetch_pc and stays stable while valid && !ready.
  - valid may be withdrawn only in a redirect cycle.
- Response handling:
  - Each imem_rsp_valid decrements inflight.
  - If drop_cnt > 0: the response is discarded and drop_cnt--.
  - Otherwise {rsp_pc, data} is pushed to the queue and rsp_pc += 4.
- Output:
  - out_* reflect the queue head combinationally from registered queue state. There is no bypass, so a response becomes visible on out_* the cycle after it arrives.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are legal at any occupancy, including full.
- Redirect cycle (redirect_valid = 1, highest priority):
  - out_valid is forced to 0; no pop occurs.
  - Queue is cleared; fetch_pc and rsp_pc are set to the aligned redirect_pc.
  - drop_cnt = inflight − (imem_rsp_valid ? 1 : 0), computed using the pre-redirect inflight. A response arriving in the redirect cycle is itself discarded.
  - inflight is updated normally; no request is issued.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Minimum latency:
  - redirect at cycle N → request at N+1 (if ready).
  - With a 1-cycle memory: response at N+2, out_valid at N+3.
- Steady state: with a 1-cycle memory, MAX_OUT ≥ 2 and out_ready = 1, throughput is 1 instruction/cycle.
- Counter widths:
  - inflight and drop_cnt: clog2(MAX_OUT+1) bits.
  - count: clog2(DEPTH+1) bits.
  - Invariant: drop_cnt ≤ inflight ≤ MAX_OUT.

Decomposition:
- Shared package fetch_pkg:
  - INSTR_W = 32, PC_STEP = 4.
  - Opcode constants OP_J = 6'b000010 and OP_JAL = 6'b000011, used by later predecode work.
  - Typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_queue:
  - Synchronous FIFO of fetch_entry_t, DEPTH entries, with flush input and count output.
  - Pointers wrap modulo DEPTH.
- Top level holds fetch_pc, rsp_pc, inflight, drop_cnt and the issue logic.

Test Plan:
- Reset release, memory always ready with 1-cycle latency, out_ready = 1 → addresses 0x0, 0x4, 0x8 … on consecutive cycles; out_pc 0x0 first, with out_pc_plus4 = 0x4.
- out_ready held 0, DEPTH = 4 → exactly 4 requests issued, then imem_req_valid = 0. Raising out_ready pops PCs 0x0, 0x4, 0x8, 0xC in order.
- Memory latency 3, MAX_OUT = 2, redirect_pc = 0x40 with 2 requests in flight → both stale responses dropped; the first out_pc after the redirect is 0x40, with no 0x8 or 0xC entries seen.
- redirect_pc = 0x103 → imem_req_addr = 0x100 and out_pc = 0x100.
- Redirect in the same cycle as a response and as out_ready = 1 → no pop reported; that response is dropped; queue is empty the next cycle.
- reset asserted while the queue is partly full with inflight = 1 → outputs return to reset values immediately. The late response after reset release is pushed as a normal RESET_PC entry, not dropped; the bench must model memory restart.
